cic_win_fetch: RTL

//  Parametrised 3x3 convolution-window fetcher for the CIC image pipeline.

---
 rtl/cic_pkg.sv | 38 +++
 rtl/cic_win_addr_gen.sv | 48 ++++
 rtl/cic_win_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC 3x3 window fetcher:
// FSM encoding, padding modes and the tap -> (dy,dx) offset tables.
package cic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int PAD_ZERO = 0;
    localparam int PAD_REPL = 1;

    localparam int       NTAPS           = 9;
    localparam logic [3:0] TAP_FIRST     = 4'd0;
    localparam logic [3:0] TAP_REUSE_FIRST = 4'd2;
    localparam logic [3:0] TAP_LAST      = 4'd8;

    // Tap t = 3*(dy+1) + (dx+1); rows of the window are taps 0-2, 3-5, 6-8.
    function automatic logic signed [1:0] tap_dy(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: tap_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: tap_dy = 2'sd0;
            default:          tap_dy = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] tap_dx(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: tap_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: tap_dx = 2'sd0;
            default:          tap_dx = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/cic_win_addr_gen.sv
// Combinational neighbour address generator: (row, col, tap) -> image address
// plus a pad flag for out-of-image taps when zero padding is selected.
module cic_win_addr_gen
    import cic_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int AW       = 12,
    parameter int PAD_MODE = 0
) (
    input  logic [AW/2-1:0] row,
    input  logic [AW/2-1:0] col,
    input  logic [3:0]      tap,
    output logic [AW-1:0]   addr,
    output logic            pad
);

    // Two guard bits so both -1 and IMG_W/IMG_H are representable as signed values.
    localparam int CW = AW/2 + 2;
    localparam logic signed [CW-1:0] H_S    = CW'(IMG_H);
    localparam logic signed [CW-1:0] W_S    = CW'(IMG_W);
    localparam logic signed [CW-1:0] HMAX_S = CW'(IMG_H - 1);
    localparam logic signed [CW-1:0] WMAX_S = CW'(IMG_W - 1);

    logic signed [1:0]    dy, dx;
    logic signed [CW-1:0] r_s, c_s, r_c, c_c;
    logic                 r_oob, c_oob;
    logic [AW-1:0]        r_a, c_a;

    always_comb begin
        dy  = tap_dy(tap);
        dx  = tap_dx(tap);
        r_s = $signed({2'b00, row}) + {{(CW-2){dy[1]}}, dy};
        c_s = $signed({2'b00, col}) + {{(CW-2){dx[1]}}, dx};

        r_oob = r_s[CW-1] || (r_s >= H_S);
        c_oob = c_s[CW-1] || (c_s >= W_S);

        r_c = r_s[CW-1] ? '0 : ((r_s >= H_S) ? HMAX_S : r_s);
        c_c = c_s[CW-1] ? '0 : ((c_s >= W_S) ? WMAX_S : c_s);

        r_a  = AW'($unsigned(r_c));
        c_a  = AW'($unsigned(c_c));
        addr = r_a * AW'(IMG_W) + c_a;
        pad  = (r_oob || c_oob) && (PAD_MODE != PAD_REPL);
    end

endmodule

// File: rtl/cic_win_fetch.sv
// 3x3 convolution-window fetcher: raster-walks every output pixel, reads the
// neighbourhood from image memory (1-cycle latency) and hands windows downstream.
//
// state   | meaning
// IDLE    | waiting for ready (image loaded)
// FETCH   | issuing one tap read per cycle (9 taps, or 3 with column reuse)
// DRAIN   | capturing the last tap returned by memory
// PRESENT | window valid, held until win_ready
// DONE    | one-cycle done pulse after the last window
module cic_win_fetch
    import cic_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int DW       = 20,
    parameter int AW       = 12,
    parameter int PAD_MODE = 0,
    parameter int REUSE    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic [AW-1:0]     iaddr,
    input  logic [DW-1:0]     idata,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [9*DW-1:0]   win_data,
    output logic [AW/2-1:0]   win_row,
    output logic [AW/2-1:0]   win_col,
    output logic              done
);

    localparam int RCW = AW/2;
    localparam logic [RCW-1:0] COL_LAST = RCW'(IMG_W - 1);
    localparam logic [RCW-1:0] ROW_LAST = RCW'(IMG_H - 1);

    state_e         state_q, state_d;
    logic [RCW-1:0] row_q, row_d;
    logic [RCW-1:0] col_q, col_d;
    logic [3:0]     tap_q, tap_d;
    logic           reuse_q, reuse_d;
    logic [AW-1:0]  iaddr_q;
    logic           cap_en_q, cap_en_d;
    logic           cap_pad_q, cap_pad_d;
    logic [3:0]     cap_tap_q, cap_tap_d;
    logic [DW-1:0]  win_q [NTAPS];
    logic [DW-1:0]  win_d [NTAPS];

    logic [AW-1:0]  gen_addr;
    logic           gen_pad;

    cic_win_addr_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .AW       (AW),
        .PAD_MODE (PAD_MODE)
    ) u_addr_gen (
        .row  (row_q),
        .col  (col_q),
        .tap  (tap_q),
        .addr (gen_addr),
        .pad  (gen_pad)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tap_d     = tap_q;
        reuse_d   = reuse_q;
        cap_en_d  = 1'b0;
        cap_pad_d = 1'b0;
        cap_tap_d = tap_q;
        iaddr     = iaddr_q;
        for (int i = 0; i < NTAPS; i++) begin
            win_d[i] = win_q[i];
        end

        // Memory data for the tap issued last cycle lands here.
        if (cap_en_q) begin
            win_d[cap_tap_q] = cap_pad_q ? '0 : idata;
        end

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    tap_d   = TAP_FIRST;
                    reuse_d = 1'b0;
                end
            end
            ST_FETCH: begin
                cap_en_d  = 1'b1;
                cap_pad_d = gen_pad;
                cap_tap_d = tap_q;
                if (!gen_pad) begin
                    iaddr = gen_addr;
                end
                if (tap_q == TAP_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + (reuse_q ? 4'd3 : 4'd1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = ST_DONE;
                    end else if (col_q == COL_LAST) begin
                        state_d = ST_FETCH;
                        col_d   = '0;
                        row_d   = row_q + RCW'(1);
                        tap_d   = TAP_FIRST;
                        reuse_d = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                        col_d   = col_q + RCW'(1);
                        if (REUSE != 0) begin
                            // Slide left; only the new right column (taps 2,5,8) is fetched.
                            win_d[0] = win_q[1];
                            win_d[1] = win_q[2];
                            win_d[3] = win_q[4];
                            win_d[4] = win_q[5];
                            win_d[6] = win_q[7];
                            win_d[7] = win_q[8];
                            tap_d    = TAP_REUSE_FIRST;
                            reuse_d  = 1'b1;
                        end else begin
                            tap_d   = TAP_FIRST;
                            reuse_d = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            tap_q     <= '0;
            reuse_q   <= 1'b0;
            iaddr_q   <= '0;
            cap_en_q  <= 1'b0;
            cap_pad_q <= 1'b0;
            cap_tap_q <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tap_q     <= tap_d;
            reuse_q   <= reuse_d;
            iaddr_q   <= iaddr;
            cap_en_q  <= cap_en_d;
            cap_pad_q <= cap_pad_d;
            cap_tap_q <= cap_tap_d;
            for (int i = 0; i < NTAPS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NTAPS; i++) begin
            win_data[i*DW +: DW] = win_q[i];
        end
    end

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_PRESENT);
    assign win_valid = (state_q == ST_PRESENT);
    assign done      = (state_q == ST_DONE);
    assign win_row   = row_q;
    assign win_col   = col_q;

endmodule
